muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_step.sv | 23 ++
 rtl/muldiv_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M funct3 encodings, FSM states and iteration count
package muldiv_pkg;
  localparam int ITER = 32;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         i_div,
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_m,
  output logic [W-1:0] o_acc,
  output logic [W-1:0] o_lo
);
  logic [W:0] w_sum;
  logic [W:0] w_shl;
  logic       w_ge;
  assign w_sum = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_m} : '0);
  assign w_shl = {i_acc, i_lo[W-1]};
  assign w_ge  = w_shl >= {1'b0, i_m};
  // on a successful subtract the difference is below i_m, so the low W bits are exact
  always_comb begin
    o_acc = i_div ? (w_ge ? w_shl[W-1:0] - i_m : w_shl[W-1:0]) : w_sum[W:1];
    o_lo  = i_div ? {i_lo[W-2:0], w_ge} : {w_sum[0], i_lo[W-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 32-step latency, register-file write-back
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int CW = $clog2(ITER);
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_acc, r_lo, r_m, r_result;
  logic              r_neg, r_rneg;
  logic              w_sa, w_sb, w_accept, w_last;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_acc, w_lo, w_q, w_r, w_res;
  logic [2*XLEN-1:0] w_prod;
  assign w_accept = r_state == S_IDLE && start;
  assign w_last   = r_state == S_RUN && r_cnt == CW'(ITER - 1);
  assign w_sa     = op_a[XLEN-1] & (funct3[2] ? ~funct3[0] : funct3[1:0] != 2'b11);
  assign w_sb     = op_b[XLEN-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
  assign w_abs_a  = w_sa ? -op_a : op_a;
  assign w_abs_b  = w_sb ? -op_b : op_b;
  muldiv_step #(.W(XLEN)) u_step (
    .i_div (r_f3[2]),
    .i_acc (r_acc),
    .i_lo  (r_lo),
    .i_m   (r_m),
    .o_acc (w_acc),
    .o_lo  (w_lo)
  );
  // sign correction is applied to the final step output so the result lands on the last edge
  always_comb begin
    w_prod = r_neg ? -{w_acc, w_lo} : {w_acc, w_lo};
    w_q    = r_neg ? -w_lo : w_lo;
    w_r    = r_rneg ? -w_acc : w_acc;
    w_res  = r_f3[2] ? (r_f3[1] ? w_r : w_q)
                     : (r_f3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (start ? S_RUN : S_IDLE)
           : r_state == S_RUN  ? (w_last ? S_DONE : S_RUN)
           : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_f3   <= funct3;
      r_rd   <= rd_in;
      r_acc  <= '0;
      r_lo   <= funct3[2] ? w_abs_a : w_abs_b;
      r_m    <= funct3[2] ? w_abs_b : w_abs_a;
      // a zero divisor yields an all-ones quotient regardless of dividend sign
      r_neg  <= (w_sa ^ w_sb) & ~(funct3[2] && op_b == '0);
      r_rneg <= w_sa;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc;
      r_lo  <= w_lo;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_res;
    end
  end
  assign busy   = r_state != S_IDLE;
  assign done   = r_state == S_DONE;
  assign result = r_result;
  assign rd_out = r_rd;
endmodule
